// File: rtl/busca_instrucao_pkg.sv
// busca_instrucao_pkg: shared FSM encoding, instruction field positions and opcode constants
package busca_instrucao_pkg;
  typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_WAIT, ST_VALID} state_t;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int SH_HI = 10, SH_LO = 6;
  localparam int FN_HI = 5, FN_LO = 0;
  localparam int IM_HI = 15, IM_LO = 0;
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_RESET = 6'b111111;
endpackage

// File: rtl/busca_instrucao_decodificador_campos.sv
// decodificador_campos: combinational split of an instruction word into its fields
module decodificador_campos
  import busca_instrucao_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm16_o
);
  assign opcode_o = ir_i[OP_HI:OP_LO];
  assign rs_o     = ir_i[RS_HI:RS_LO];
  assign rt_o     = ir_i[RT_HI:RT_LO];
  assign rd_o     = ir_i[RD_HI:RD_LO];
  assign shamt_o  = ir_i[SH_HI:SH_LO];
  assign funct_o  = ir_i[FN_HI:FN_LO];
  assign imm16_o  = ir_i[IM_HI:IM_LO];
endmodule

// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction fetch stage owning the PC, fixed-latency memory read and IR handshake
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 2,
  parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        pc_load,
  input  logic [31:0] pc_in,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic [5:0]  OPCODE,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic        fault
);
  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] pc_q, pc_d, ir_q, pend_q;
  logic        pend_v_q, fault_q, mem_rd_q, valid_q, ld_ok;
  assign ld_ok = pc_load && (pc_in[1:0] == 2'b00);
  assign pc_plus4 = pc_q + 32'd4;
  // a same-cycle aligned load beats a latched target, which beats sequential flow
  assign pc_d = ld_ok ? pc_in : pend_v_q ? pend_q : pc_plus4;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      fault_q  <= 1'b0;
      mem_rd_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_q  <= ST_FETCH;
          mem_rd_q <= 1'b1;
        end
        ST_FETCH: begin
          state_q  <= ST_WAIT;
          mem_rd_q <= 1'b0;
          cnt_q    <= 3'(MEM_LAT);
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            ir_q    <= mem_data;
            valid_q <= 1'b1;
            state_q <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (pc_load && !ld_ok) fault_q <= 1'b1;
          if (instr_ready) begin
            pc_q     <= pc_d;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            valid_q  <= 1'b0;
            mem_rd_q <= 1'b1;
            state_q  <= ST_FETCH;
          end else if (ld_ok) begin
            pend_q   <= pc_in;
            pend_v_q <= 1'b1;
          end
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  decodificador_campos u_dec (
    .ir_i    (ir_q),
    .opcode_o(OPCODE),
    .rs_o    (rs),
    .rt_o    (rt),
    .rd_o    (rd),
    .shamt_o (shamt),
    .funct_o (funct),
    .imm16_o (imm16)
  );
endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: directed and randomized checks of the fetch stage against a transaction-level model
module tb_busca_instrucao;
  localparam int L = 2;
  logic        clk, rst_n, mem_rd, pc_load, instr_ready, instr_valid, fault;
  logic [31:0] mem_addr, mem_data, pc_in, pc, pc_plus4, ir;
  logic [5:0]  OPCODE, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  int n_cmp = 0, n_err = 0;
  logic [31:0] m_pc, m_pend;
  logic        m_pend_v, m_fault;
  logic        rv [L];
  logic [31:0] ra [L];

  busca_instrucao #(.MEM_LAT(L), .PC_RESET(32'h0)) dut (
    .clk(clk), .reset(rst_n), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .pc_load(pc_load), .pc_in(pc_in), .instr_ready(instr_ready), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .ir(ir), .OPCODE(OPCODE), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm16(imm16), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : ((a * 32'h9E37_79B1) ^ 32'hA5A5_0000);
  endfunction

  // memory model: data for a read appears exactly L cycles after its strobe
  always @(posedge clk) begin
    rv[0] <= mem_rd;
    ra[0] <= mem_addr;
    for (int i = 1; i < L; i++) begin
      rv[i] <= rv[i-1];
      ra[i] <= ra[i-1];
    end
  end
  assign mem_data = rv[L-1] ? word(ra[L-1]) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] v;
    v = $urandom();
    return ($urandom_range(3) == 0) ? v : (v & 32'hFFFF_FFFC);
  endfunction

  task automatic reset_model();
    m_pc = 32'h0;
    m_pend = 32'h0;
    m_pend_v = 1'b0;
    m_fault = 1'b0;
  endtask

  // called at the negedge of the fetch cycle; returns at the negedge of the first valid cycle
  task automatic fetch_and_check();
    logic [31:0] w;
    w = word(m_pc);
    chk("mem_rd_fetch", 32'(mem_rd), 32'd1);
    chk("mem_addr", mem_addr, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("valid_fetch", 32'(instr_valid), 32'd0);
    for (int i = 0; i <= L; i++) begin
      pc_load = 1'($urandom_range(1));
      pc_in = $urandom();
      instr_ready = 1'($urandom_range(1));
      @(negedge clk);
      if (i < L) begin
        chk("mem_rd_wait", 32'(mem_rd), 32'd0);
        chk("valid_wait", 32'(instr_valid), 32'd0);
        chk("fault_wait", 32'(fault), 32'(m_fault));
      end
    end
    pc_load = 1'b0;
    instr_ready = 1'b0;
    chk("valid", 32'(instr_valid), 32'd1);
    chk("mem_rd_valid", 32'(mem_rd), 32'd0);
    chk("ir", ir, w);
    chk("pc", pc, m_pc);
    chk("opcode", 32'(OPCODE), w >> 26);
    chk("rs", 32'(rs), (w >> 21) & 32'd31);
    chk("rt", 32'(rt), (w >> 16) & 32'd31);
    chk("rd", 32'(rd), (w >> 11) & 32'd31);
    chk("shamt", 32'(shamt), (w >> 6) & 32'd31);
    chk("funct", 32'(funct), w & 32'd63);
    chk("imm16", 32'(imm16), w & 32'hFFFF);
  endtask

  task automatic valid_cycle(input logic ld, input logic [31:0] v, input logic rdy);
    logic ok;
    ok = ld && (v[1:0] == 2'b00);
    pc_load = ld;
    pc_in = v;
    instr_ready = rdy;
    if (ld && !ok) m_fault = 1'b1;
    if (rdy) begin
      m_pc = ok ? v : m_pend_v ? m_pend : m_pc + 32'd4;
      m_pend_v = 1'b0;
    end else if (ok) begin
      m_pend = v;
      m_pend_v = 1'b1;
    end
    @(negedge clk);
    pc_load = 1'b0;
    instr_ready = 1'b0;
    chk("fault", 32'(fault), 32'(m_fault));
    if (!rdy) begin
      chk("valid_hold", 32'(instr_valid), 32'd1);
      chk("ir_hold", ir, word(m_pc));
      chk("mem_rd_hold", 32'(mem_rd), 32'd0);
    end else begin
      chk("valid_drop", 32'(instr_valid), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    pc_load = 1'b0;
    pc_in = 32'h0;
    instr_ready = 1'b0;
    reset_model();
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_opcode", 32'(OPCODE), 32'd0);
    chk("rst_imm16", 32'(imm16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch_and_check();
    chk("first_opcode", 32'(OPCODE), 32'd8);
    chk("first_rt", 32'(rt), 32'd8);
    chk("first_imm16", 32'(imm16), 32'd5);
    // sequential flow with ready asserted on the first valid cycle
    for (int k = 0; k < 3; k++) begin
      valid_cycle(1'b0, 32'h0, 1'b1);
      fetch_and_check();
    end
    valid_cycle(1'b1, 32'h40, 1'b0);
    valid_cycle(1'b0, 32'h0, 1'b0);
    valid_cycle(1'b0, 32'h0, 1'b1);
    fetch_and_check();
    valid_cycle(1'b1, 32'h40, 1'b0);
    valid_cycle(1'b1, 32'h80, 1'b1);
    fetch_and_check();
    valid_cycle(1'b1, 32'h42, 1'b1);
    fetch_and_check();
    valid_cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    fetch_and_check();
    valid_cycle(1'b0, 32'h0, 1'b1);
    fetch_and_check();
    for (int n = 0; n < 40; n++) begin
      for (int e = 0; e < int'($urandom_range(3)); e++)
        valid_cycle(1'($urandom_range(1)), rnd_pc(), 1'b0);
      valid_cycle(1'($urandom_range(1)), rnd_pc(), 1'b1);
      fetch_and_check();
    end
    // make fault sticky-high, then reset in the middle of a wait
    valid_cycle(1'b1, 32'h0000_0101, 1'b1);
    chk("fault_pre_rst", 32'(fault), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_mem_rd", 32'(mem_rd), 32'd0);
    chk("arst_ir", ir, 32'h0);
    chk("arst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    chk("late_data_ir", ir, 32'h0);
    @(negedge clk);
    chk("late_data_ir2", ir, 32'h0);
    rst_n = 1'b1;
    reset_model();
    @(negedge clk);
    fetch_and_check();
    // reset while a target is pending must discard it
    valid_cycle(1'b1, 32'h100, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("vrst_valid", 32'(instr_valid), 32'd0);
    chk("vrst_ir", ir, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    @(negedge clk);
    fetch_and_check();
    valid_cycle(1'b0, 32'h0, 1'b1);
    fetch_and_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
